// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one variable-latency memory port between instruction fetch
//            and data access; data wins by default, and a streak limit keeps
//            fetch from starving. Optional macro ARB_TIMEOUT_EN adds a
//            mem_ack timeout that aborts the access and pulses err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_dmtype,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_dmtype,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("mem_port_arbiter: MAX_D_STREAK or TIMEOUT out of range");
    end

    state_t     state;
    logic       owner_d;
    logic [3:0] d_streak;
    logic       streak_full;
    logic       grant_d;
    logic       grant_i;

    // Fetch only overrides a pending data request once data has had its streak
    assign streak_full = (d_streak == 4'(MAX_D_STREAK));
    assign grant_d     = d_req && !(i_req && streak_full);
    assign grant_i     = i_req && !grant_d;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            d_streak   <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_dmtype <= 3'b000;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
`ifdef ARB_TIMEOUT_EN
            err        <= 1'b0;
            tmo_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d    <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_dmtype <= d_dmtype;
                        state      <= BUSY;
                    end else if (grant_i) begin
                        owner_d    <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_dmtype <= 3'b000;
                        state      <= BUSY;
                    end
                    // Streak only counts data grants made while fetch waits
                    if (!i_req) begin
                        d_streak <= 4'd0;
                    end else if (grant_d) begin
                        if (!streak_full) begin
                            d_streak <= d_streak + 4'd1;
                        end
                    end else begin
                        d_streak <= 4'd0;
                    end
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt <= 8'd0;
`endif
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        err     <= 1'b1;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            d_rdata <= DW'(32'hDEADBEEF);
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= DW'(32'hDEADBEEF);
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err     <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_dmtype;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_dmtype;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_dmtype   (d_dmtype),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_dmtype (mem_dmtype),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [2:0]  dmt;
        int          k;
        logic [31:0] rdata;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [2:0]  exp_dmt;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic        resp_en = 1'b0;
    int          ack_wait = 0;
    int          wcnt = 0;
    logic [31:0] resp_data = '0;
    logic        prev_req = 1'b0;
    int          n_grants = 0;
    logic [9:0]  grant_log = '0;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no response expected a ready pulse", name);
    endtask

    // One clock; observe just after the edge, then model the memory's ack.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req && !prev_req) begin
            if (n_grants < 10) grant_log[n_grants] = (mem_addr == 32'h100);
            n_grants++;
        end
        prev_req = mem_req;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (resp_en && mem_req) begin
            if (wcnt == ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = resp_data;
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, {mem_req, mem_we, i_ready, d_ready, err, mem_dmtype}, 64'd0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
        check({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic done;
        done      = 1'b0;
        ack_wait  = v.k;
        resp_data = v.rdata;
        wcnt      = 0;
        resp_en   = 1'b1;
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata; d_dmtype = v.dmt;
        for (int c = 1; c <= 20 && !done; c++) begin
            tick();
            if (mem_req) begin
                check({tag, "_cmd"}, {mem_addr, mem_we, mem_dmtype}, {v.exp_addr, v.exp_we, v.exp_dmt});
                if (v.exp_we) check({tag, "_wdata"}, mem_wdata, v.dwdata);
            end
            if (i_ready || d_ready) begin
                done = 1'b1;
                check({tag, "_winner"}, {i_ready, d_ready}, {~v.exp_d, v.exp_d});
                check({tag, "_latency"}, c, 2 + v.k);
                check({tag, "_i_rdata"}, i_rdata, v.exp_irdata);
                check({tag, "_d_rdata"}, d_rdata, v.exp_drdata);
                check({tag, "_err"}, err, 1'b0);
            end
        end
        if (!done) bound_fail({tag, "_ready"});
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        check({tag, "_pulse"}, {i_ready, d_ready, mem_req}, 64'd0);
        tick();
    endtask

    initial begin
        vec_t hv;
        logic done;
        int   req_cycles;

        //        ireq iaddr   dreq dwe daddr   dwdata  dmt   k  rdata          exp_d addr  we dmt   irdata         drdata
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 0, 32'h00000013, 1'b0, 32'h100,  1'b0, 3'd0, 32'h00000013, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0,        3'd2, 1, 32'h11223344, 1'b1, 32'h2000, 1'b0, 3'd2, 32'h00000013, 32'h11223344};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,   32'hCAFEBABE, 3'd2, 3, 32'h55555555, 1'b1, 32'h40,   1'b1, 3'd2, 32'h00000013, 32'h11223344};
        vecs[3] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h999,  32'h1234,     3'd7, 2, 32'hA0A0A0A0, 1'b0, 32'h104,  1'b0, 3'd0, 32'hA0A0A0A0, 32'h11223344};
        vecs[4] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h3000, 32'h0,        3'd4, 0, 32'h00000077, 1'b1, 32'h3000, 1'b0, 3'd4, 32'hA0A0A0A0, 32'h00000077};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h3004, 32'h0,        3'd5, 0, 32'hFFFF8000, 1'b1, 32'h3004, 1'b0, 3'd5, 32'hA0A0A0A0, 32'hFFFF8000};

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_dmtype = 3'd0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_vals("reset");
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held: four data grants, then one fetch, repeating
        ack_wait = 0; wcnt = 0; resp_en = 1'b1; resp_data = 32'h0BADF00D;
        n_grants = 0; grant_log = '0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_dmtype = 3'd2;
        for (int c = 0; c < 100 && n_grants < 10; c++) tick();
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();
        check("streak_count", n_grants, 10);
        check("streak_order", grant_log, 10'b1000010000);

        // Reset while BUSY, then a stale ack
        resp_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h200;
        tick(); tick();
        check("busy_before_reset", mem_req, 1'b1);
        reset = 1'b1; i_req = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_vals("midreset");
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        check("late_ack_0", {i_ready, d_ready, mem_req, err}, 64'd0);
        tick();
        check("late_ack_1", {i_ready, d_ready, mem_req, err, i_rdata}, 64'd0);
        hv = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1, 32'h00000099,
               1'b0, 32'h300, 1'b0, 3'd0, 32'h00000099, 32'h0};
        run_vec(hv, "post_reset");

        // Spurious ack while idle with no requests
        resp_en = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
        tick();
        check("spurious_0", {i_ready, d_ready, mem_req, err}, 64'd0);
        tick();
        check("spurious_1", {i_ready, d_ready, mem_req, err}, 64'd0);
        check("spurious_rdata", {i_rdata, d_rdata}, {32'h00000099, 32'h0});

`ifdef ARB_TIMEOUT_EN
        resp_en = 1'b0; done = 1'b0; req_cycles = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1; d_dmtype = 3'd2;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (mem_req) req_cycles++;
            if (d_ready || i_ready) begin
                done = 1'b1;
                check("tmo_ready_err", {i_ready, d_ready, err}, 3'b011);
                check("tmo_rdata", d_rdata, 32'hDEADBEEF);
                check("tmo_req_cycles", req_cycles, 15);
            end
        end
        if (!done) bound_fail("tmo_ready");
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("tmo_pulse", {d_ready, err, mem_req}, 64'd0);
        tick();
`else
        req_cycles = 0;
        done = 1'b0;
        if (done) req_cycles = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
